transmitter: RTL
================

TRANSMITTER -- requirements
Module: transmitter

Interface
REQ-001 Parameter CLKS_PER_BIT, default 1085, SHALL set the number of clken-qualified clk cycles per serial bit; legal range 2..65535.
REQ-002 Port clk, input, 1 bit, SHALL be the single clock; all state changes occur on its rising edge.
REQ-003 Port rst, input, 1 bit, SHALL be the reset; synchronous and active-high.
REQ-004 Port clken, input, 1 bit, SHALL be the clock enable; state, counter and bit index advance only on edges where clken=1.
REQ-005 Port wr_en, input, 1 bit, SHALL be the request to send data_in.
REQ-006 Port data_in, input, 8 bits, SHALL be the byte to transmit; sampled only on acceptance.
REQ-007 Port tx, output, 1 bit, SHALL be the serial line; idle/mark level 1.
REQ-008 Port busy, output, 1 bit, SHALL be 1 from the cycle after acceptance until the frame ends.
REQ-009 Port done, output, 1 bit, SHALL pulse for one clk cycle when a frame completes.

Function
REQ-010 Frame format SHALL be 8N1: start bit 0, data bits 0..7 LSB first, one stop bit 1; no parity.
REQ-011 States SHALL be IDLE, START, DATA, STOP; any other encoding SHALL return to IDLE on the next enabled edge.
REQ-012 Acceptance SHALL occur on an edge with state=IDLE, clken=1, wr_en=1; data_in is latched into an internal shift/hold register and the state moves to START.
REQ-013 wr_en while busy=1, or while clken=0, SHALL be ignored; the byte is neither queued nor corrupted.
REQ-014 tx SHALL be registered: 1 in IDLE, 0 in START, data[bitpos] in DATA, 1 in STOP.
REQ-015 Counter: 16-bit, cleared on every state or bit transition, incremented on each enabled edge; a bit ends when counter = CLKS_PER_BIT-1 on an enabled edge.
REQ-016 Each of START, each of the 8 DATA bits, and STOP SHALL hold tx for exactly CLKS_PER_BIT enabled cycles; a frame spans exactly 10*CLKS_PER_BIT enabled cycles.
REQ-017 bitpos: 3-bit, 0 on entry to DATA, increments at each DATA bit end; at the end of bit 7 the state moves to STOP and bitpos returns to 0.
REQ-018 At the end of STOP the state SHALL return to IDLE, busy SHALL fall, and done SHALL be 1 for that single clk cycle.
REQ-019 Back-to-back: wr_en=1 on the first enabled edge in IDLE after done SHALL start the next frame with no extra idle bit beyond the stop bit.
REQ-020 With clken=0, tx, busy, state, counter and bitpos SHALL hold; done SHALL be 0.
REQ-021 Changes to data_in after acceptance SHALL NOT affect the frame in progress.

Reset
REQ-022 rst=1 on a clk edge SHALL force state=IDLE, counter=0, bitpos=0, tx=1, busy=0, done=0, hold register=0, regardless of clken.
REQ-023 rst asserted mid-frame SHALL abort the frame immediately; the line returns to 1 on the next edge and no done pulse is emitted.
REQ-024 rst and wr_en on the same edge: rst SHALL win; the request is dropped.

Verification (CLKS_PER_BIT=4 unless stated)
REQ-025 clken=1, wr_en pulse with data_in=8'hA5 -> tx = 0,1,0,1,0,0,1,0,1,1, each level 4 clk; busy high 40 clk; done single pulse at the frame end.
REQ-026 clken toggling 1,0,1,0..., send 8'h3C -> same bit sequence, each bit 8 clk, frame 80 clk; all outputs hold on clken=0 cycles.
REQ-027 wr_en held high with data_in changed to 8'hFF mid-frame during 8'h81 -> first frame is 8'h81 unaltered; a second frame 8'hFF starts immediately after done.
REQ-028 rst pulsed during DATA bit 3 of 8'h00 -> tx=1 and busy=0 on the next edge, no done pulse; next wr_en with 8'h55 transmits a clean frame.
REQ-029 Loopback tx to the team's UART receiver with matching CLKS_PER_BIT=16, bytes 8'h00, 8'hFF, 8'h5A, 8'hC3 -> receiver data equals each byte after its frame.
REQ-030 Default CLKS_PER_BIT=1085, clken=1, one byte -> busy high for exactly 10850 clk.

Source files
------------

// File: rtl/transmitter.sv
// 8N1 serial transmitter: accepts a byte when idle and shifts it out LSB first,
// each bit lasting CLKS_PER_BIT clock-enabled cycles.
module transmitter #(
    parameter int CLKS_PER_BIT = 1085
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clken,
    input  logic       wr_en,
    input  logic [7:0] data_in,
    output logic       tx,
    output logic       busy,
    output logic       done
);

    localparam logic [15:0] LAST_COUNT = 16'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t      state, state_next;
    logic [15:0] counter, counter_next;
    logic [2:0]  bitpos, bitpos_next;
    logic [2:0]  bitpos_inc;
    logic [7:0]  hold, hold_next;
    logic        tx_next, busy_next, done_next;
    logic        bit_end;

    assign bit_end    = (counter == LAST_COUNT);
    assign bitpos_inc = bitpos + 3'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            counter <= '0;
            bitpos  <= '0;
            hold    <= '0;
            tx      <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_next;
            counter <= counter_next;
            bitpos  <= bitpos_next;
            hold    <= hold_next;
            tx      <= tx_next;
            busy    <= busy_next;
            done    <= done_next;
        end
    end

    // tx, busy and done are computed one edge early so they come straight from flops
    always_comb begin
        state_next   = state;
        counter_next = counter;
        bitpos_next  = bitpos;
        hold_next    = hold;
        tx_next      = tx;
        busy_next    = busy;
        done_next    = 1'b0;

        if (clken) begin
            case (state)
                IDLE: begin
                    tx_next      = 1'b1;
                    busy_next    = 1'b0;
                    counter_next = '0;
                    bitpos_next  = '0;
                    if (wr_en) begin
                        state_next = START;
                        hold_next  = data_in;
                        tx_next    = 1'b0;
                        busy_next  = 1'b1;
                    end
                end

                START: begin
                    if (bit_end) begin
                        state_next   = DATA;
                        counter_next = '0;
                        bitpos_next  = '0;
                        tx_next      = hold[0];
                    end else begin
                        counter_next = counter + 16'd1;
                    end
                end

                DATA: begin
                    if (bit_end) begin
                        counter_next = '0;
                        if (bitpos == 3'd7) begin
                            state_next  = STOP;
                            bitpos_next = '0;
                            tx_next     = 1'b1;
                        end else begin
                            bitpos_next = bitpos_inc;
                            tx_next     = hold[bitpos_inc];
                        end
                    end else begin
                        counter_next = counter + 16'd1;
                    end
                end

                STOP: begin
                    if (bit_end) begin
                        state_next   = IDLE;
                        counter_next = '0;
                        tx_next      = 1'b1;
                        busy_next    = 1'b0;
                        done_next    = 1'b1;
                    end else begin
                        counter_next = counter + 16'd1;
                    end
                end

                default: begin
                    state_next   = IDLE;
                    counter_next = '0;
                    bitpos_next  = '0;
                    tx_next      = 1'b1;
                    busy_next    = 1'b0;
                end
            endcase
        end
    end

endmodule
